// File: rtl/eth_rx_frame.sv
// MII (4-bit) Ethernet receiver: preamble/SFD sync, destination filter, 9-bit sequence field,
// payload delivery with FCS stripped and CRC-32 check. Optional macro: RX_SEQ_CHECK_EN.
module eth_rx_frame #(
    parameter logic [47:0] MAC_ADDR = 48'h020202020202,
    parameter int          PKT_MAX  = 479,
    parameter int          LEN_MAX  = 2047
) (
    input  logic        rxc,
    input  logic        rst,
    input  logic        rxdv,
    input  logic [3:0]  rxd,
    output logic [7:0]  dataout,
    output logic        data_valid,
    output logic        sof,
    output logic        eof,
    output logic        crc_ok,
    output logic        len_err,
    output logic        align_err,
    output logic [10:0] frame_len,
    output logic [8:0]  pkt_num,
    output logic        seq_err,
    output logic        indicate
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PREAMBLE = 3'd1;
    localparam logic [2:0] S_DEST     = 3'd2;
    localparam logic [2:0] S_SEQ      = 3'd3;
    localparam logic [2:0] S_PAYLOAD  = 3'd4;
    localparam logic [2:0] S_DROP     = 3'd5;
    localparam logic [2:0] S_WAIT_LOW = 3'd6;

    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [11:0] LEN_MAX_V   = 12'(LEN_MAX);

    if (PKT_MAX < 0 || PKT_MAX > 511 || LEN_MAX < 4 || LEN_MAX > 2047) begin : g_param_check
        $error("eth_rx_frame: PKT_MAX must fit 9 bits and LEN_MAX must lie in 4..2047");
    end

    // Reflected CRC-32, one byte per call, LSB first.
    function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'd0, b};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    logic [2:0]  state;
    logic [3:0]  nib_lo;
    logic        phase;
    logic [2:0]  bcnt;
    logic        mac_ok;
    logic        bc_ok;
    logic [31:0] crc;
    logic [7:0]  seq_lo;
    logic [8:0]  seq_cnt;
    logic [7:0]  byte_p0, byte_p1, byte_p2, byte_p3;
    logic [11:0] pcnt;
    logic [10:0] emit_cnt;
    logic        first_pend;
    logic        drop_eof;

    logic [7:0]  byte_in;
    logic [31:0] crc_upd;
    logic [47:0] mac_sh;
    logic [7:0]  mac_byte;
    logic        in_frame;
    logic        fall_evt;
    logic        frame_good;
    logic        good_evt;
    logic        bad_evt;

    always_comb begin
        byte_in    = {rxd, nib_lo};
        crc_upd    = crc_next(crc, byte_in);
        mac_sh     = MAC_ADDR << {bcnt, 3'b000};
        mac_byte   = mac_sh[47:40];
        in_frame   = (state == S_DEST) || (state == S_SEQ) || (state == S_PAYLOAD);
        fall_evt   = in_frame && !rxdv;
        frame_good = (state == S_PAYLOAD) && !phase && (crc == CRC_RESIDUE) && (pcnt >= 12'd4);
        good_evt   = fall_evt && frame_good;
        bad_evt    = (fall_evt && !frame_good) || ((state == S_DROP) && !rxdv && drop_eof);
    end

    always_ff @(posedge rxc or posedge rst) begin
        if (rst) begin
            state      <= S_WAIT_LOW;
            nib_lo     <= 4'd0;
            phase      <= 1'b0;
            bcnt       <= 3'd0;
            mac_ok     <= 1'b0;
            bc_ok      <= 1'b0;
            crc        <= CRC_INIT;
            seq_lo     <= 8'd0;
            seq_cnt    <= 9'd0;
            byte_p0    <= 8'd0;
            byte_p1    <= 8'd0;
            byte_p2    <= 8'd0;
            byte_p3    <= 8'd0;
            pcnt       <= 12'd0;
            emit_cnt   <= 11'd0;
            first_pend <= 1'b0;
            drop_eof   <= 1'b0;
            dataout    <= 8'd0;
            data_valid <= 1'b0;
            sof        <= 1'b0;
            eof        <= 1'b0;
            crc_ok     <= 1'b0;
            len_err    <= 1'b0;
            align_err  <= 1'b0;
            frame_len  <= 11'd0;
            pkt_num    <= 9'd0;
            indicate   <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            sof        <= 1'b0;
            eof        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rxdv)
                        state <= (rxd == 4'h5) ? S_PREAMBLE : S_WAIT_LOW;
                end
                S_PREAMBLE: begin
                    if (!rxdv) begin
                        state <= S_IDLE;
                    end else if (rxd == 4'hD) begin
                        state      <= S_DEST;
                        phase      <= 1'b0;
                        bcnt       <= 3'd0;
                        mac_ok     <= 1'b1;
                        bc_ok      <= 1'b1;
                        crc        <= CRC_INIT;
                        pcnt       <= 12'd0;
                        emit_cnt   <= 11'd0;
                        first_pend <= 1'b0;
                        drop_eof   <= 1'b0;
                    end else if (rxd != 4'h5) begin
                        state <= S_WAIT_LOW;
                    end
                end
                S_DEST, S_SEQ, S_PAYLOAD: begin
                    if (!rxdv) begin
                        state     <= S_IDLE;
                        eof       <= 1'b1;
                        align_err <= phase;
                        len_err   <= 1'b0;
                        crc_ok    <= frame_good;
                        frame_len <= emit_cnt;
                        if (frame_good) begin
                            pkt_num  <= seq_cnt;
                            indicate <= ~indicate;
                        end
                    end else begin
                        phase <= ~phase;
                        if (!phase) begin
                            nib_lo <= rxd;
                        end else begin
                            crc <= crc_upd;
                            if (state == S_DEST) begin
                                mac_ok <= mac_ok && (byte_in == mac_byte);
                                bc_ok  <= bc_ok && (byte_in == 8'hFF);
                                if (bcnt == 3'd5) begin
                                    bcnt <= 3'd0;
                                    // Unmatched destination is dropped silently, with no eof.
                                    if ((mac_ok && (byte_in == mac_byte)) || (bc_ok && (byte_in == 8'hFF)))
                                        state <= S_SEQ;
                                    else
                                        state <= S_DROP;
                                end else begin
                                    bcnt <= bcnt + 3'd1;
                                end
                            end else if (state == S_SEQ) begin
                                if (bcnt == 3'd0) begin
                                    seq_lo <= byte_in;
                                    bcnt   <= 3'd1;
                                end else begin
                                    seq_cnt    <= {byte_in[0], seq_lo};
                                    state      <= S_PAYLOAD;
                                    first_pend <= 1'b1;
                                end
                            end else if (pcnt == LEN_MAX_V) begin
                                state    <= S_DROP;
                                drop_eof <= 1'b1;
                            end else begin
                                pcnt    <= pcnt + 12'd1;
                                byte_p0 <= byte_in;
                                byte_p1 <= byte_p0;
                                byte_p2 <= byte_p1;
                                byte_p3 <= byte_p2;
                                // A byte leaves only once four newer bytes exist, so the FCS never does.
                                if (pcnt >= 12'd4) begin
                                    dataout    <= byte_p3;
                                    data_valid <= 1'b1;
                                    sof        <= first_pend;
                                    first_pend <= 1'b0;
                                    emit_cnt   <= emit_cnt + 11'd1;
                                end
                            end
                        end
                    end
                end
                S_DROP: begin
                    if (!rxdv) begin
                        state <= S_IDLE;
                        if (drop_eof) begin
                            eof       <= 1'b1;
                            crc_ok    <= 1'b0;
                            len_err   <= 1'b1;
                            align_err <= 1'b0;
                            frame_len <= emit_cnt;
                        end
                    end
                end
                S_WAIT_LOW: begin
                    if (!rxdv)
                        state <= S_IDLE;
                end
                default: state <= S_WAIT_LOW;
            endcase
        end
    end

`ifdef RX_SEQ_CHECK_EN
    localparam logic [8:0] PKT_MAX_V = 9'(PKT_MAX);

    logic       have_prev;
    logic [8:0] seq_expect;

    always_comb begin
        seq_expect = (pkt_num == PKT_MAX_V) ? 9'd0 : pkt_num + 9'd1;
    end

    // pkt_num still holds the previous good counter when the good eof is decided.
    always_ff @(posedge rxc or posedge rst) begin
        if (rst) begin
            have_prev <= 1'b0;
            seq_err   <= 1'b0;
        end else if (good_evt) begin
            have_prev <= 1'b1;
            seq_err   <= have_prev && (seq_cnt != seq_expect);
        end else if (bad_evt) begin
            seq_err <= 1'b0;
        end
    end
`else
    logic unused_evt;
    assign unused_evt = good_evt ^ bad_evt;
    assign seq_err    = 1'b0;
`endif

endmodule

// File: tb/tb_eth_rx_frame.sv
// Directed bench for eth_rx_frame: frame-level reference model plus per-cycle output comparison.
module tb_eth_rx_frame;

    logic        rxc = 1'b0;
    logic        rst;
    logic        rxdv;
    logic [3:0]  rxd;
    logic [7:0]  dataout;
    logic        data_valid, sof, eof, crc_ok, len_err, align_err, seq_err, indicate;
    logic [10:0] frame_len;
    logic [8:0]  pkt_num;

    eth_rx_frame dut (
        .rxc(rxc), .rst(rst), .rxdv(rxdv), .rxd(rxd),
        .dataout(dataout), .data_valid(data_valid), .sof(sof), .eof(eof),
        .crc_ok(crc_ok), .len_err(len_err), .align_err(align_err),
        .frame_len(frame_len), .pkt_num(pkt_num), .seq_err(seq_err), .indicate(indicate)
    );

    always #5 rxc = ~rxc;

`ifdef RX_SEQ_CHECK_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif

    typedef struct {
        logic        crc_ok;
        logic        align;
        logic [10:0] flen;
        logic [8:0]  pkt;
        logic        ind;
        logic        serr;
    } eof_t;

    int total = 0;
    int bad   = 0;

    logic [7:0] fr[$];
    logic [7:0] exp_data[$];
    eof_t       exp_eof[$];
    bit         exp_first;
    logic [8:0] m_pkt;
    logic       m_ind;
    bit         m_prev;
    int         dv_seen;
    int         eof_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, fr[i]};
            for (int k = 0; k < 8; k++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    // dest, sequence, payload (pattern 0: i, else i*7+3), then FCS low byte first.
    task automatic build(input logic [47:0] dst, input logic [8:0] seq, input int plen, input int pat);
        logic [31:0] f;
        fr.delete();
        for (int i = 0; i < 6; i++) fr.push_back(8'(dst >> (8 * (5 - i))));
        fr.push_back(seq[7:0]);
        fr.push_back({7'd0, seq[8]});
        for (int i = 0; i < plen; i++) fr.push_back((pat == 0) ? 8'(i) : 8'(i * 7 + 3));
        f = fcs_of(fr.size());
        for (int i = 0; i < 4; i++) fr.push_back(8'(f >> (8 * i)));
    endtask

    // Frame-level expectation derived from the byte list actually sent.
    task automatic model_frame(input bit odd);
        int   n, p, emitted;
        bit   dest_ok, good;
        eof_t e;
        logic [8:0] seqv, nxt;
        n = fr.size();
        p = n - 8;
        dest_ok = 1'b1;
        if (n >= 6) begin
            bit mac, bc;
            mac = 1'b1; bc = 1'b1;
            for (int i = 0; i < 6; i++) begin
                if (fr[i] != 8'h02) mac = 1'b0;
                if (fr[i] != 8'hFF) bc = 1'b0;
            end
            dest_ok = mac || bc;
        end
        if (!dest_ok) return;
        emitted = (p > 4) ? p - 4 : 0;
        for (int i = 0; i < emitted; i++) exp_data.push_back(fr[8 + i]);
        exp_first = (emitted > 0);
        good = !odd && (p >= 4) && ({fr[n-1], fr[n-2], fr[n-3], fr[n-4]} == fcs_of(n - 4));
        e.crc_ok = good;
        e.align  = odd;
        e.flen   = 11'(emitted);
        e.serr   = 1'b0;
        if (good) begin
            seqv = {fr[7][0], fr[6]};
            nxt  = (m_pkt == 9'd479) ? 9'd0 : m_pkt + 9'd1;
            e.serr = SEQ_EN && m_prev && (seqv != nxt);
            m_pkt  = seqv;
            m_ind  = ~m_ind;
            m_prev = 1'b1;
        end
        e.pkt = m_pkt;
        e.ind = m_ind;
        exp_eof.push_back(e);
    endtask

    task automatic nib(input logic [3:0] v);
        @(posedge rxc); #2;
        rxdv = 1'b1;
        rxd  = v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge rxc); #2;
            rxdv = 1'b0;
            rxd  = 4'h0;
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_dataout"},   dataout, 0);
        check({tag, "_dv"},        data_valid, 0);
        check({tag, "_eof"},       eof, 0);
        check({tag, "_pkt_num"},   pkt_num, 0);
        check({tag, "_indicate"},  indicate, 0);
        check({tag, "_crc_ok"},    crc_ok, 0);
        check({tag, "_frame_len"}, frame_len, 0);
    endtask

    // rst_at: byte index before which rst is pulsed with rxdv held high (-1: none).
    task automatic send_frame(input bit odd, input int rst_at);
        dv_seen  = 0;
        eof_seen = 0;
        model_frame(odd);
        for (int i = 0; i < 15; i++) nib(4'h5);
        nib(4'hD);
        for (int i = 0; i < fr.size(); i++) begin
            if (i == rst_at) begin
                @(posedge rxc); #2;
                rst = 1'b1;
                exp_data.delete();
                exp_eof.delete();
                exp_first = 1'b0;
                m_pkt = 9'd0; m_ind = 1'b0; m_prev = 1'b0;
                @(posedge rxc); #2;
                rst = 1'b0;
                @(negedge rxc);
                check_zero_outputs("midrst");
            end
            nib(fr[i][3:0]);
            nib(fr[i][7:4]);
        end
        if (odd) nib(4'hA);
        idle(8);
        check("data_drained", exp_data.size(), 0);
        check("eof_drained", exp_eof.size(), 0);
    endtask

    always @(negedge rxc) begin
        if (!rst) begin
            if (data_valid) begin
                dv_seen++;
                check("dv_expected", exp_data.size() != 0, 1);
                if (exp_data.size() != 0) begin
                    check("dataout", dataout, exp_data.pop_front());
                    check("sof", sof, exp_first);
                    exp_first = 1'b0;
                end
            end
            if (eof) begin
                eof_t e;
                eof_seen++;
                check("eof_expected", exp_eof.size() != 0, 1);
                if (exp_eof.size() != 0) begin
                    e = exp_eof.pop_front();
                    check("crc_ok", crc_ok, e.crc_ok);
                    check("align_err", align_err, e.align);
                    check("len_err", len_err, 0);
                    check("frame_len", frame_len, e.flen);
                    check("pkt_num", pkt_num, e.pkt);
                    check("indicate", indicate, e.ind);
                    check("seq_err", seq_err, e.serr);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; rxdv = 1'b0; rxd = 4'h0;
        m_pkt = 9'd0; m_ind = 1'b0; m_prev = 1'b0; exp_first = 1'b0;
        dv_seen = 0; eof_seen = 0;
        repeat (3) @(posedge rxc);
        @(negedge rxc);
        check_zero_outputs("reset");
        #2 rst = 1'b0;
        idle(4);

        // Reference frame: payload 00..FF.
        build(48'h020202020202, 9'd5, 256, 0);
        send_frame(1'b0, -1);
        check("f1_dv_count", dv_seen, 256);
        check("f1_eof_count", eof_seen, 1);
        check("f1_frame_len", frame_len, 256);
        check("f1_crc_ok", crc_ok, 1);
        check("f1_pkt_num", pkt_num, 5);
        check("f1_indicate", indicate, 1);

        // Same frame with one payload bit flipped.
        build(48'h020202020202, 9'd5, 256, 0);
        fr[8 + 10] = fr[8 + 10] ^ 8'h04;
        send_frame(1'b0, -1);
        check("f2_dv_count", dv_seen, 256);
        check("f2_crc_ok", crc_ok, 0);
        check("f2_pkt_num", pkt_num, 5);
        check("f2_indicate", indicate, 1);

        // Wrong destination: silent drop.
        build(48'h020202020203, 9'd6, 32, 1);
        send_frame(1'b0, -1);
        check("f3_dv_count", dv_seen, 0);
        check("f3_eof_count", eof_seen, 0);

        build(48'h020202020202, 9'd6, 16, 1);
        send_frame(1'b0, -1);
        check("f4_pkt_num", pkt_num, 6);
        check("f4_indicate", indicate, 0);
        check("f4_frame_len", frame_len, 16);

        build(48'hFFFFFFFFFFFF, 9'd7, 5, 1);
        send_frame(1'b0, -1);
        check("f5_pkt_num", pkt_num, 7);

        // FCS only, empty payload.
        build(48'h020202020202, 9'd8, 0, 0);
        send_frame(1'b0, -1);
        check("f6_crc_ok", crc_ok, 1);
        check("f6_frame_len", frame_len, 0);
        check("f6_pkt_num", pkt_num, 8);

        // Reset mid-payload with rxdv held high.
        build(48'h020202020202, 9'd20, 40, 0);
        send_frame(1'b0, 18);
        check("f7_eof_count", eof_seen, 0);
        check("f7_pkt_num", pkt_num, 0);

        build(48'h020202020202, 9'd9, 24, 1);
        send_frame(1'b0, -1);
        check("f8_pkt_num", pkt_num, 9);
        check("f8_indicate", indicate, 1);
        check("f8_crc_ok", crc_ok, 1);

        // Three payload nibbles after the sequence field.
        build(48'h020202020202, 9'd10, 1, 0);
        void'(fr.pop_back()); void'(fr.pop_back()); void'(fr.pop_back()); void'(fr.pop_back());
        send_frame(1'b1, -1);
        check("f9_eof_count", eof_seen, 1);
        check("f9_align_err", align_err, 1);
        check("f9_crc_ok", crc_ok, 0);
        check("f9_frame_len", frame_len, 0);
        check("f9_pkt_num", pkt_num, 9);

        // rxdv drops inside the destination field.
        build(48'h020202020202, 9'd11, 4, 0);
        while (fr.size() > 3) void'(fr.pop_back());
        send_frame(1'b0, -1);
        check("f10_eof_count", eof_seen, 1);
        check("f10_crc_ok", crc_ok, 0);

        // Sequence wrap and gap.
        build(48'h020202020202, 9'd478, 8, 1);
        send_frame(1'b0, -1);
        build(48'h020202020202, 9'd479, 8, 0);
        send_frame(1'b0, -1);
`ifdef RX_SEQ_CHECK_EN
        check("seq_479", seq_err, 0);
`endif
        build(48'h020202020202, 9'd0, 8, 1);
        send_frame(1'b0, -1);
`ifdef RX_SEQ_CHECK_EN
        check("seq_0", seq_err, 0);
`endif
        build(48'h020202020202, 9'd2, 8, 0);
        send_frame(1'b0, -1);
`ifdef RX_SEQ_CHECK_EN
        check("seq_2", seq_err, 1);
`endif
        check("seq_pkt_num", pkt_num, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
